// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: PC source encoding and fetch sequencer states.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      PC_SEQ  = 2'd0,
      PC_JR   = 2'd1,
      PC_JUMP = 2'd2,
      PC_BR   = 2'd3
   } pcsrc_t;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      PENDING = 2'd1,
      HALTED  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC controller: turns ihit/stall/halt/redirect requests into pc_en/PCSrc,
// buffering a redirect that arrives while imem is busy and replaying it as a JR load.
module fetch_sequencer
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ihit,
   input  logic              stall,
   input  logic              halt,
   input  logic              redir_valid,
   input  logic [1:0]        redir_src,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] redir_target,
   output logic              pc_en,
   output logic [1:0]        pc_src,
   output logic [WORD_W-1:0] replay_addr,
   output logic              replay_sel,
   output logic              flush,
   output logic              imemREN,
   output logic              halted,
   output logic [CNT_W-1:0]  redir_count
);

   fetch_state_t      state_reg, state_next;
   logic [WORD_W-1:0] replay_addr_reg, replay_addr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              count_inc;
   logic              eff_redir;
   logic              advance;

   // Source 0 is illegal and a not-taken branch is just sequential fetch.
   assign eff_redir = redir_valid &
                      ((redir_src == PC_JR) | (redir_src == PC_JUMP) |
                       ((redir_src == PC_BR) & branch_taken));
   assign advance   = ihit & ~stall;

   always_comb begin
      state_next       = state_reg;
      replay_addr_next = replay_addr_reg;
      count_inc        = 1'b0;
      pc_en            = 1'b0;
      pc_src           = PC_SEQ;
      replay_sel       = 1'b0;
      flush            = 1'b0;
      imemREN          = 1'b0;
      halted           = 1'b0;
      if (!RST) begin
         case (state_reg)
            FETCH: begin
               imemREN = 1'b1;
               if (eff_redir && advance) begin
                  pc_en     = 1'b1;
                  pc_src    = redir_src;
                  flush     = 1'b1;
                  count_inc = 1'b1;
               end else if (eff_redir) begin
                  replay_addr_next = redir_target;
                  state_next       = PENDING;
               end else if (halt) begin
                  state_next = HALTED;
               end else begin
                  pc_en = advance;
               end
            end
            PENDING: begin
               // Requests seen here come from wrong-path instructions.
               imemREN = 1'b1;
               if (advance) begin
                  pc_en      = 1'b1;
                  pc_src     = PC_JR;
                  replay_sel = 1'b1;
                  flush      = 1'b1;
                  count_inc  = 1'b1;
                  state_next = FETCH;
               end
            end
            HALTED: begin
               halted = 1'b1;
            end
            default: begin
               state_next = FETCH;
            end
         endcase
      end
   end

   assign count_next  = (count_inc && (count_reg != {CNT_W{1'b1}})) ?
                        count_reg + 1'b1 : count_reg;
   assign replay_addr = replay_addr_reg;
   assign redir_count = count_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg       <= FETCH;
         replay_addr_reg <= '0;
         count_reg       <= '0;
      end else begin
         state_reg       <= state_next;
         replay_addr_reg <= replay_addr_next;
         count_reg       <= count_next;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; a narrow-counter instance checks saturation.
module tb_fetch_sequencer;

   logic        CLK;
   logic        RST;
   logic        ihit, stall, halt, redir_valid, branch_taken;
   logic [1:0]  redir_src;
   logic [31:0] redir_target;

   logic        pc_en, replay_sel, flush, imemREN, halted;
   logic [1:0]  pc_src;
   logic [31:0] replay_addr;
   logic [15:0] redir_count;

   logic        b_pc_en, b_replay_sel, b_flush, b_imemREN, b_halted;
   logic [1:0]  b_pc_src;
   logic [31:0] b_replay_addr;
   logic [3:0]  b_redir_count;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_sequencer #(.WORD_W(32), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt(halt),
      .redir_valid(redir_valid), .redir_src(redir_src), .branch_taken(branch_taken),
      .redir_target(redir_target), .pc_en(pc_en), .pc_src(pc_src),
      .replay_addr(replay_addr), .replay_sel(replay_sel), .flush(flush),
      .imemREN(imemREN), .halted(halted), .redir_count(redir_count)
   );

   fetch_sequencer #(.WORD_W(32), .CNT_W(4)) dut_sat (
      .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt(halt),
      .redir_valid(redir_valid), .redir_src(redir_src), .branch_taken(branch_taken),
      .redir_target(redir_target), .pc_en(b_pc_en), .pc_src(b_pc_src),
      .replay_addr(b_replay_addr), .replay_sel(b_replay_sel), .flush(b_flush),
      .imemREN(b_imemREN), .halted(b_halted), .redir_count(b_redir_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs;
      ihit = 0; stall = 0; halt = 0; redir_valid = 0;
      redir_src = 2'd0; branch_taken = 0; redir_target = 32'h0;
   endtask

   task automatic test_reset;
      clear_inputs();
      RST = 1; ihit = 1;
      for (int i = 0; i < 2; i++) begin
         #2;
         n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en got %b want 0", pc_en); end
         n_checks++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL reset_imemREN got %b want 0", imemREN); end
         n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
         tick();
      end
      RST = 0;
      #2;
      n_checks++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL post_reset_imemREN got %b want 1", imemREN); end
      n_checks++; if (redir_count !== 16'd0) begin n_fail++; $display("FAIL post_reset_count got %0d want 0", redir_count); end
      n_checks++; if (pc_src !== 2'd0) begin n_fail++; $display("FAIL post_reset_pc_src got %0d want 0", pc_src); end
      n_checks++; if (replay_addr !== 32'h0) begin n_fail++; $display("FAIL post_reset_replay_addr got %h want 0", replay_addr); end
      $display("reset: pc_en=%b imemREN=%b count=%0d", pc_en, imemREN, redir_count);
      tick();
   endtask

   task automatic test_stall;
      logic [2:0] stall_seq;
      logic [2:0] exp_en;
      stall_seq = 3'b101; exp_en = 3'b010;
      clear_inputs(); ihit = 1;
      for (int i = 2; i >= 0; i--) begin
         stall = stall_seq[i];
         #2;
         n_checks++; if (pc_en !== exp_en[i]) begin n_fail++; $display("FAIL stall_pc_en step %0d got %b want %b", 2 - i, pc_en, exp_en[i]); end
         n_checks++; if (pc_src !== 2'd0) begin n_fail++; $display("FAIL stall_pc_src step %0d got %0d want 0", 2 - i, pc_src); end
         $display("stall=%b: pc_en=%b pc_src=%0d", stall, pc_en, pc_src);
         tick();
      end
   endtask

   task automatic test_redirect;
      clear_inputs();
      redir_valid = 1; redir_src = 2'd2; redir_target = 32'h40; ihit = 1;
      #2;
      n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL jump_pc_en got %b want 1", pc_en); end
      n_checks++; if (pc_src !== 2'd2) begin n_fail++; $display("FAIL jump_pc_src got %0d want 2", pc_src); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush got %b want 1", flush); end
      n_checks++; if (replay_sel !== 1'b0) begin n_fail++; $display("FAIL jump_replay_sel got %b want 0", replay_sel); end
      $display("jump 0x40: pc_en=%b pc_src=%0d flush=%b", pc_en, pc_src, flush);
      tick();
      clear_inputs();
      #2;
      n_checks++; if (redir_count !== 16'd1) begin n_fail++; $display("FAIL jump_count got %0d want 1", redir_count); end
      tick();
   endtask

   task automatic test_pending;
      clear_inputs();
      redir_valid = 1; redir_src = 2'd3; branch_taken = 0; redir_target = 32'h88; ihit = 1;
      #2;
      n_checks++; if (pc_src !== 2'd0) begin n_fail++; $display("FAIL ntbr_pc_src got %0d want 0", pc_src); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL ntbr_flush got %b want 0", flush); end
      n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL ntbr_pc_en got %b want 1", pc_en); end
      $display("branch not taken: pc_en=%b pc_src=%0d flush=%b", pc_en, pc_src, flush);
      tick();
      redir_src = 2'd1; redir_target = 32'h1234; ihit = 0;
      #2;
      n_checks++; if (redir_count !== 16'd1) begin n_fail++; $display("FAIL ntbr_count got %0d want 1", redir_count); end
      n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL jr_miss_pc_en got %b want 0", pc_en); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jr_miss_flush got %b want 0", flush); end
      tick();
      // Wrong-path requests during PENDING must not disturb the buffered target.
      redir_src = 2'd2; redir_target = 32'h9999; halt = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL pending_pc_en cycle %0d got %b want 0", i, pc_en); end
         n_checks++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL pending_imemREN cycle %0d got %b want 1", i, imemREN); end
         n_checks++; if (replay_addr !== 32'h1234) begin n_fail++; $display("FAIL pending_addr cycle %0d got %h want 00001234", i, replay_addr); end
         $display("pending cycle %0d: pc_en=%b replay_addr=%h", i, pc_en, replay_addr);
         tick();
      end
      ihit = 1;
      #2;
      n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL replay_pc_en got %b want 1", pc_en); end
      n_checks++; if (pc_src !== 2'd1) begin n_fail++; $display("FAIL replay_pc_src got %0d want 1", pc_src); end
      n_checks++; if (replay_sel !== 1'b1) begin n_fail++; $display("FAIL replay_sel got %b want 1", replay_sel); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL replay_flush got %b want 1", flush); end
      n_checks++; if (replay_addr !== 32'h1234) begin n_fail++; $display("FAIL replay_addr got %h want 00001234", replay_addr); end
      $display("replay: pc_en=%b pc_src=%0d replay_sel=%b addr=%h", pc_en, pc_src, replay_sel, replay_addr);
      tick();
      clear_inputs(); ihit = 1;
      #2;
      n_checks++; if (redir_count !== 16'd2) begin n_fail++; $display("FAIL replay_count got %0d want 2", redir_count); end
      n_checks++; if (replay_sel !== 1'b0) begin n_fail++; $display("FAIL after_replay_sel got %b want 0", replay_sel); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL after_replay_halted got %b want 0", halted); end
      tick();
   endtask

   task automatic test_halt;
      clear_inputs();
      halt = 1; stall = 1; ihit = 1;
      #2;
      n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL halt_pc_en got %b want 0", pc_en); end
      tick();
      clear_inputs();
      redir_valid = 1; redir_src = 2'd2; redir_target = 32'h500; ihit = 1;
      for (int i = 0; i < 2; i++) begin
         #2;
         n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halted cycle %0d got %b want 1", i, halted); end
         n_checks++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL halted_imemREN cycle %0d got %b want 0", i, imemREN); end
         n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL halted_pc_en cycle %0d got %b want 0", i, pc_en); end
         n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL halted_flush cycle %0d got %b want 0", i, flush); end
         $display("halted cycle %0d: halted=%b imemREN=%b", i, halted, imemREN);
         tick();
      end
      n_checks++; if (redir_count !== 16'd2) begin n_fail++; $display("FAIL halted_count got %0d want 2", redir_count); end
      clear_inputs();
      RST = 1;
      #2;
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b want 0", halted); end
      tick();
      RST = 0;
      #2;
      n_checks++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL unhalt_imemREN got %b want 1", imemREN); end
      n_checks++; if (redir_count !== 16'd0) begin n_fail++; $display("FAIL unhalt_count got %0d want 0", redir_count); end
      n_checks++; if (replay_addr !== 32'h0) begin n_fail++; $display("FAIL unhalt_replay_addr got %h want 0", replay_addr); end
      $display("reset from halt: halted=%b imemREN=%b", halted, imemREN);
      tick();
   endtask

   task automatic test_halt_redirect;
      clear_inputs();
      halt = 1; redir_valid = 1; redir_src = 2'd2; redir_target = 32'h80; ihit = 1;
      #2;
      n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL haltjmp_pc_en got %b want 1", pc_en); end
      n_checks++; if (pc_src !== 2'd2) begin n_fail++; $display("FAIL haltjmp_pc_src got %0d want 2", pc_src); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL haltjmp_flush got %b want 1", flush); end
      tick();
      clear_inputs();
      #2;
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL haltjmp_halted got %b want 0", halted); end
      n_checks++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL haltjmp_imemREN got %b want 1", imemREN); end
      n_checks++; if (redir_count !== 16'd1) begin n_fail++; $display("FAIL haltjmp_count got %0d want 1", redir_count); end
      $display("halt+jump: pc_en=%b halted=%b count=%0d", pc_en, halted, redir_count);
      tick();
   endtask

   task automatic test_saturate;
      clear_inputs();
      redir_valid = 1; redir_src = 2'd2; ihit = 1;
      for (int i = 0; i < 13; i++) begin
         redir_target = 32'h100 + 32'(i);
         tick();
      end
      clear_inputs();
      #2;
      n_checks++; if (b_redir_count !== 4'd14) begin n_fail++; $display("FAIL sat_pre got %0d want 14", b_redir_count); end
      redir_valid = 1; redir_src = 2'd1; ihit = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         #2;
         n_checks++; if (b_redir_count !== 4'd15) begin n_fail++; $display("FAIL sat_hold %0d got %0d want 15", i, b_redir_count); end
         n_checks++; if (redir_count !== 16'(15 + i)) begin n_fail++; $display("FAIL wide_count %0d got %0d want %0d", i, redir_count, 15 + i); end
         $display("saturate step %0d: narrow=%0d wide=%0d", i, b_redir_count, redir_count);
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect();
      test_pending();
      test_halt();
      test_halt_redirect();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
